// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets, CTRL/STATUS bit
// positions and handshake FSM encoding.
package mmio_responder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int OFF_IN     = 0;
    localparam int OFF_OUT    = 1;
    localparam int OFF_EDGE   = 2;
    localparam int OFF_TIMER  = 3;
    localparam int OFF_CMP    = 4;
    localparam int OFF_STATUS = 5;
    localparam int OFF_CTRL   = 6;
    localparam int NUM_REGS   = 7;

    localparam int CTRL_TMR_EN  = 0;
    localparam int CTRL_CMP_IE  = 1;
    localparam int CTRL_EDGE_IE = 2;
    localparam int CTRL_W       = 3;

    localparam int STAT_CMP_HIT   = 0;
    localparam int STAT_EDGE_PEND = 1;

    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_responder_timer.sv
// Prescaled 32-bit up-counter with compare register and sticky CMP_HIT flag.
module mmio_responder_timer
    import mmio_responder_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        cmp_we,
    input  logic [31:0] cmp_val,
    input  logic        hit_clr,
    output logic [31:0] timer,
    output logic [31:0] cmp,
    output logic        hit
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic          tick;
    logic          hit_set;

    assign tick    = en && (pcnt == PW'(PRESCALE - 1));
    assign hit_set = en && (timer == cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            timer <= '0;
            cmp   <= CMP_RST;
            hit   <= 1'b0;
        end else begin
            // A bus load overrides the tick that might land on the same edge
            if (load) begin
                timer <= load_val;
                pcnt  <= '0;
            end else if (en) begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
                if (tick) timer <= timer + 32'd1;
            end
            if (cmp_we) cmp <= cmp_val;
            hit <= (hit & ~hit_clr) | hit_set;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on the cpu data bus: synchronised input port with sticky edge
// flags, output port, prescaled timer with compare, and a level interrupt.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int              ADDR_W     = 4,
    parameter int              IO_W       = 32,
    parameter int              PRESCALE   = 1,
    parameter logic [IO_W-1:0] IO_OUT_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    input  logic [IO_W-1:0]   io_in,
    output logic [IO_W-1:0]   io_out,
    output logic              irq
);

    state_t state, state_nxt;

    logic [31:0]       addr_ext;
    logic              accept, wr, mapped;
    logic              sel_out, sel_edge, sel_timer, sel_cmp, sel_status, sel_ctrl;
    logic [IO_W-1:0]   sync1, sync2, sync3;
    logic [IO_W-1:0]   edge_q, edge_clr, out_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       timer, cmp;
    logic              cmp_hit;
    logic [31:0]       rd_val, rdata_q;
    logic              err_q, irq_q;

    assign addr_ext   = 32'(addr);
    assign accept     = (state == ST_IDLE) && req;
    assign wr         = accept && we;
    assign mapped     = addr_ext < 32'(NUM_REGS);
    assign sel_out    = wr && (addr_ext == 32'(OFF_OUT));
    assign sel_edge   = wr && (addr_ext == 32'(OFF_EDGE));
    assign sel_timer  = wr && (addr_ext == 32'(OFF_TIMER));
    assign sel_cmp    = wr && (addr_ext == 32'(OFF_CMP));
    assign sel_status = wr && (addr_ext == 32'(OFF_STATUS));
    assign sel_ctrl   = wr && (addr_ext == 32'(OFF_CTRL));
    assign edge_clr   = sel_edge ? wdata[IO_W-1:0] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read mux sees pre-edge register values, so the snapshot is taken at accept
    always_comb begin
        rd_val = '0;
        case (addr_ext)
            32'(OFF_IN):     rd_val = 32'(sync2);
            32'(OFF_OUT):    rd_val = 32'(out_q);
            32'(OFF_EDGE):   rd_val = 32'(edge_q);
            32'(OFF_TIMER):  rd_val = timer;
            32'(OFF_CMP):    rd_val = cmp;
            32'(OFF_STATUS): begin
                rd_val[STAT_CMP_HIT]   = cmp_hit;
                rd_val[STAT_EDGE_PEND] = |edge_q;
            end
            32'(OFF_CTRL):   rd_val = 32'(ctrl_q);
            default:         rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                err_q   <= !mapped;
                rdata_q <= (we || !mapped) ? '0 : rd_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            edge_q <= '0;
            out_q  <= IO_OUT_RST;
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync1  <= io_in;
            sync2  <= sync1;
            sync3  <= sync2;
            // New rise wins over a W1C clear of the same bit
            edge_q <= (edge_q & ~edge_clr) | (sync2 & ~sync3);
            if (sel_out)  out_q  <= wdata[IO_W-1:0];
            if (sel_ctrl) ctrl_q <= wdata[CTRL_W-1:0];
            irq_q <= (cmp_hit & ctrl_q[CTRL_CMP_IE]) | ((|edge_q) & ctrl_q[CTRL_EDGE_IE]);
        end
    end

    mmio_responder_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_TMR_EN]),
        .load     (sel_timer),
        .load_val (wdata),
        .cmp_we   (sel_cmp),
        .cmp_val  (wdata),
        .hit_clr  (sel_status && wdata[STAT_CMP_HIT]),
        .timer    (timer),
        .cmp      (cmp),
        .hit      (cmp_hit)
    );

    assign ack    = (state == ST_RESP);
    assign rdata  = ack ? rdata_q : '0;
    assign err    = ack & err_q;
    assign io_out = out_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: register-map table, directed handshake/edge/timer
// sequences, and random bus traffic against a register-level reference model.
module tb_mmio_responder;

    localparam int              ADDR_W     = 4;
    localparam int              IO_W       = 8;
    localparam int              PRESCALE   = 4;
    localparam logic [IO_W-1:0] IO_OUT_RST = 8'h5A;
    localparam logic [31:0]     IO_MASK    = 32'((64'd1 << IO_W) - 1);

    logic              clk = 1'b0;
    logic              rst, req, we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, rdata;
    logic              ack, err, irq;
    logic [IO_W-1:0]   io_in, io_out;

    int errors = 0;
    int checks = 0;

    mmio_responder #(
        .ADDR_W(ADDR_W), .IO_W(IO_W), .PRESCALE(PRESCALE), .IO_OUT_RST(IO_OUT_RST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .io_in(io_in), .io_out(io_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: register file indexed by offset plus sync history
    logic [31:0] m_reg [0:7];
    logic [31:0] m_sync [0:2];
    int          m_pcnt;
    logic        m_busy, m_err, m_irq, m_hit;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0:       return m_sync[1];
            1, 2, 3, 4: return m_reg[a];
            5:       return {30'd0, (m_reg[2] != 0), m_hit};
            6:       return m_reg[6];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] o_edge, o_timer, o_cmp, o_ctrl, rise;
        logic        o_hit, acc, wr;
        int          a;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'd0;
            foreach (m_sync[i]) m_sync[i] = 32'd0;
            m_reg[1] = 32'(IO_OUT_RST);
            m_reg[4] = 32'hFFFF_FFFF;
            m_pcnt = 0; m_busy = 0; m_err = 0; m_irq = 0; m_hit = 0; m_rdata = 0;
            return;
        end
        a = int'(addr);
        o_edge = m_reg[2]; o_timer = m_reg[3]; o_cmp = m_reg[4]; o_ctrl = m_reg[6]; o_hit = m_hit;
        acc = req && !m_busy;
        wr  = acc && we;
        if (acc) begin
            m_err   = (a >= 7);
            m_rdata = (we || a >= 7) ? 32'd0 : m_read(a);
        end
        m_busy = acc;
        m_irq  = (o_hit & o_ctrl[1]) | ((o_edge != 0) & o_ctrl[2]);
        rise   = m_sync[1] & ~m_sync[2];
        m_sync[2] = m_sync[1];
        m_sync[1] = m_sync[0];
        m_sync[0] = 32'(io_in);
        m_reg[2] = (o_edge & ~((wr && a == 2) ? (wdata & IO_MASK) : 32'd0)) | rise;
        if (wr && a == 1) m_reg[1] = wdata & IO_MASK;
        if (wr && a == 4) m_reg[4] = wdata;
        if (wr && a == 6) m_reg[6] = wdata & 32'd7;
        m_hit = (o_hit && !(wr && a == 5 && wdata[0])) || (o_ctrl[0] && o_timer == o_cmp);
        if (wr && a == 3) begin
            m_reg[3] = wdata;
            m_pcnt   = 0;
        end else if (o_ctrl[0]) begin
            if (m_pcnt == PRESCALE - 1) begin
                m_pcnt   = 0;
                m_reg[3] = o_timer + 32'd1;
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ack", 32'(ack), 32'(m_busy));
        chk("err", 32'(err), m_busy ? 32'(m_err) : 32'd0);
        chk("rdata", rdata, m_busy ? m_rdata : 32'd0);
        chk("io_out", 32'(io_out), m_reg[1]);
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus(input logic w, input int a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
        req = 1'b1; we = w; addr = a[ADDR_W-1:0]; wdata = d;
        cycle();
        chk("bus_ack", 32'(ack), 32'd1);
        rd = rdata; e = err;
        req = 1'b0;
        cycle();
        chk("bus_ack_drop", 32'(ack), 32'd0);
    endtask

    typedef struct {
        logic        we;
        int          addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; io_in = '0;
        cycle(); cycle();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_io_out", 32'(io_out), 32'h5A);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        cycle();

        tbl[0]  = '{1'b0, 4,  32'h0,          32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{1'b0, 3,  32'h0,          32'h0,         1'b0};
        tbl[2]  = '{1'b0, 6,  32'h0,          32'h0,         1'b0};
        tbl[3]  = '{1'b1, 1,  32'h0000_01A5,  32'h0,         1'b0};
        tbl[4]  = '{1'b0, 1,  32'h0,          32'hA5,        1'b0};
        tbl[5]  = '{1'b1, 6,  32'hFFFF_FFF8,  32'h0,         1'b0};
        tbl[6]  = '{1'b0, 6,  32'h0,          32'h0,         1'b0};
        tbl[7]  = '{1'b0, 9,  32'h0,          32'h0,         1'b1};
        tbl[8]  = '{1'b1, 12, 32'hFFFF_FFFF,  32'h0,         1'b1};
        tbl[9]  = '{1'b0, 7,  32'h0,          32'h0,         1'b1};
        tbl[10] = '{1'b0, 15, 32'h0,          32'h0,         1'b1};
        tbl[11] = '{1'b1, 5,  32'hFFFF_FFFE,  32'h0,         1'b0};
        tbl[12] = '{1'b0, 5,  32'h0,          32'h0,         1'b0};
        tbl[13] = '{1'b1, 4,  32'h1234_5678,  32'h0,         1'b0};
        tbl[14] = '{1'b0, 4,  32'h0,          32'h1234_5678, 1'b0};
        tbl[15] = '{1'b1, 3,  32'hDEAD_BEEF,  32'h0,         1'b0};
        tbl[16] = '{1'b0, 3,  32'h0,          32'hDEAD_BEEF, 1'b0};
        tbl[17] = '{1'b0, 0,  32'h0,          32'h0,         1'b0};
        tbl[18] = '{1'b1, 0,  32'hFFFF_FFFF,  32'h0,         1'b0};
        tbl[19] = '{1'b0, 1,  32'h0,          32'hA5,        1'b0};
        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, e);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end
        chk("io_out_a5", 32'(io_out), 32'hA5);

        // Single read: ack exactly one cycle after req, single pulse
        req = 1'b1; we = 1'b0; addr = 4'd1;
        cycle();
        chk("lat_ack", 32'(ack), 32'd1);
        req = 1'b0;
        cycle();
        chk("lat_pulse", 32'(ack), 32'd0);

        // req held: ack every second cycle
        req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("b2b_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        req = 1'b0;
        cycle();

        // Edge flags
        io_in = 8'h08;
        cycle(); cycle(); cycle();
        bus(1'b0, 0, 32'h0, rd, e); chk("in_bit3", rd, 32'h8);
        bus(1'b0, 2, 32'h0, rd, e); chk("edge_bit3", rd, 32'h8);
        bus(1'b1, 2, 32'h8, rd, e);
        bus(1'b0, 2, 32'h0, rd, e); chk("edge_cleared", rd, 32'h0);
        io_in = 8'h00;
        for (int i = 0; i < 4; i++) cycle();
        io_in = 8'h08;
        cycle(); cycle();
        bus(1'b1, 2, 32'h8, rd, e);
        bus(1'b0, 2, 32'h0, rd, e); chk("edge_set_wins", rd, 32'h8);
        bus(1'b1, 2, 32'h8, rd, e);
        bus(1'b0, 5, 32'h0, rd, e); chk("status_no_pend", rd, 32'h0);

        // Timer wrap and compare
        bus(1'b1, 3, 32'hFFFF_FFFE, rd, e);
        bus(1'b1, 4, 32'h1, rd, e);
        bus(1'b1, 6, 32'h3, rd, e);
        n = 0;
        while (!irq && n < 60) begin
            cycle();
            n++;
        end
        chk("irq_latency", 32'(n), 32'd13);
        bus(1'b0, 5, 32'h0, rd, e); chk("cmp_hit", rd, 32'h1);
        bus(1'b1, 6, 32'h0, rd, e);
        bus(1'b0, 3, 32'h0, rd, e); chk("timer_after_wrap", rd, 32'h2);
        for (int i = 0; i < 10; i++) cycle();
        bus(1'b0, 3, 32'h0, rd, e); chk("timer_frozen", rd, 32'h2);
        bus(1'b1, 5, 32'h1, rd, e);
        bus(1'b0, 5, 32'h0, rd, e); chk("cmp_hit_clr", rd, 32'h0);
        chk("irq_clr", 32'(irq), 32'd0);

        // Load on a tick edge beats the increment
        bus(1'b1, 6, 32'h1, rd, e);
        n = 0;
        while (m_pcnt != PRESCALE - 1 && n < 10) begin
            cycle();
            n++;
        end
        chk("tick_align", 32'(m_pcnt), 32'(PRESCALE - 1));
        bus(1'b1, 3, 32'h100, rd, e);
        bus(1'b0, 3, 32'h0, rd, e); chk("timer_load_wins", rd, 32'h100);
        bus(1'b1, 6, 32'h0, rd, e);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) io_in = IO_W'($urandom);
            if ($urandom_range(4) == 0) begin
                cycle();
            end else begin
                bus(1'($urandom_range(1)), int'($urandom_range(9)), $urandom, rd, e);
            end
        end

        // Reset during the response cycle drops the ack
        req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 32'h33;
        cycle();
        chk("pre_rst_ack", 32'(ack), 32'd1);
        rst = 1'b1; req = 1'b0;
        cycle();
        chk("rst_resp_ack", 32'(ack), 32'd0);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_no_ack", 32'(ack), 32'd0);
        end
        chk("rst2_io_out", 32'(io_out), 32'h5A);
        bus(1'b0, 4, 32'h0, rd, e); chk("rst2_cmp", rd, 32'hFFFF_FFFF);
        bus(1'b0, 3, 32'h0, rd, e); chk("rst2_timer", rd, 32'h0);
        bus(1'b0, 6, 32'h0, rd, e); chk("rst2_ctrl", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
